if_prefetch: RTL and testbench
==============================

# if_prefetch

Instruction prefetch stage of the Tiny RISC-V front end, directly upstream of the instruction FIFO (`sync_fifo`). It issues sequential word fetches to instruction memory, keeps up to `MAX_OUT` requests in flight, and writes each returned `{pc, instr}` pair into the FIFO. A credit counter guarantees the FIFO can never overflow. On a redirect it restarts at a new PC, flushes the FIFO and discards stale in-flight responses.

## Interface
- `XLEN`, 32: address/instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `MAX_OUT`, 2: maximum outstanding bus requests, 1..7.
- `FIFO_DEPTH`, 16: downstream FIFO depth; initial credit count.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `redirect_i`  in  1  restart fetch at `redirect_pc_i`; single-cycle pulse.
- `redirect_pc_i`  in  XLEN  new fetch PC; bits [1:0] ignored.
- `req_valid_o`  out  1  fetch request valid.
- `req_ready_i`  in  1  memory accepts request.
- `req_addr_o`  out  XLEN  word-aligned fetch address.
- `rsp_valid_i`  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
- `rsp_data_i`  in  XLEN  instruction word.
- `rsp_err_i`  in  1  bus error on this response. Used only with `IF_PREFETCH_ERR_EN`.
- `fifo_wr_en_o`  out  1  FIFO push.
- `fifo_data_o`  out  2*XLEN  {pc, instr}.
- `fifo_rd_i`  in  1  downstream FIFO pop, same pulse as the FIFO's `rd_en && ~empty`.
- `fifo_flush_o`  out  1  clear FIFO pointers.
- `fetch_err_o`  out  1  sticky fetch error. Present only with `IF_PREFETCH_ERR_EN`.

## Operation
- **Registers:**
  - `fetch_pc`: next request address.
  - `rsp_pc`: PC of the oldest outstanding request.
  - `outstanding`: 0..`MAX_OUT`.
  - `credits`: 0..`FIFO_DEPTH`; counts FIFO slots not yet reserved.
  - `discard`: number of stale responses still to drop.
- **States:**
  - `BOOT`: entered on reset. Loads `fetch_pc = rsp_pc = RESET_PC`, then goes to `FETCH`.
  - `FETCH`: issues requests. A redirect moves to `FLUSH` if any response is still pending (`outstanding` minus any response arriving this cycle > 0); otherwise the state stays `FETCH`.
  - `FLUSH`: drops responses, decrementing `discard` on each. Returns to `FETCH` when `discard` reaches 0. No new requests are issued in `FLUSH`.
  - `HALT`: error stop; error build only. Only reset leaves it.
- **Request issue:** `req_valid_o = (state==FETCH) && outstanding<MAX_OUT && credits>0`.
- **On accept (`req_valid_o && req_ready_i`):**
  - `fetch_pc += 4`, wrapping modulo 2^XLEN.
  - `outstanding++`.
  - `credits--`.
- **While waiting for accept:** `req_addr_o` stays stable while `req_valid_o && !req_ready_i`. A redirect may withdraw a pending, unaccepted request; the memory tolerates withdrawal.
- **On a non-discarded response:**
  - Registered push: `fifo_wr_en_o=1` and `fifo_data_o={rsp_pc, rsp_data_i}` in the next cycle.
  - `rsp_pc += 4`.
  - `outstanding--`.
- **Credit updates:**
  - `fifo_rd_i` increments `credits`.
  - Accept and `fifo_rd_i` in the same cycle leave `credits` unchanged.
  - Credits never exceed `FIFO_DEPTH`.
- **Redirect:**
  - `fetch_pc = rsp_pc = {redirect_pc_i[XLEN-1:2], 2'b00}`.
  - `credits = FIFO_DEPTH`; `fifo_rd_i` is ignored in that cycle.
  - `discard` = requests still pending after this cycle, including any accepted in the same cycle.
  - Any push scheduled for the next cycle is suppressed.
  - `fifo_flush_o` pulses for exactly one cycle, the cycle after the redirect.
- **Redirect during `FLUSH`:** updates the PCs, pulses flush again and recomputes `discard`; the block stays in `FLUSH`.

## Timing
- **Reset values:**
  - `req_valid_o=0`, `req_addr_o=RESET_PC`.
  - `fifo_wr_en_o=0`, `fifo_data_o=0`.
  - `fifo_flush_o=0`, `fetch_err_o=0`.
  - All counters 0 except `credits=FIFO_DEPTH`.
- **Startup:** first `req_valid_o` is 2 cycles after reset release (`BOOT` lasts one cycle).
- **Latency:** response to FIFO push is 1 cycle.
- **Throughput:** with `MAX_OUT>=2`, one request per cycle is sustained given 1-cycle memory latency and a draining FIFO.
- **Reset mid-operation:** all state is discarded immediately. The memory side is reset by the same `rst_n`.

## Configuration
- **`IF_PREFETCH_ERR_EN` defined:**
  - A non-discarded response with `rsp_err_i=1` is not pushed.
  - `fetch_err_o` is set next cycle.
  - The block enters `HALT`.
  - Responses still in flight are dropped.
- **`IF_PREFETCH_ERR_EN` undefined:**
  - `rsp_err_i` is ignored; every response is pushed.
  - `fetch_err_o` port and the `HALT` state are absent.

## Structure
- **Package `tiny_pkg`:** holds `XLEN`, `RESET_PC`, the `if_state_e` enum {BOOT, FETCH, FLUSH, HALT} and the `fetch_pkt_t` struct {pc, instr}.
- **Sub-module `prefetch_credit`:** the saturating credit counter, with reserve, release and reload-on-flush inputs and a `credits>0` output.

## Test plan
- **Reset and boot:** release reset with `req_ready_i=1` and 1-cycle memory -> addresses 0x0, 0x4, 0x8… issued every cycle; pushes carry matching PCs.
- **Backpressure:** no `fifo_rd_i`, `FIFO_DEPTH=16` -> exactly 16 accepts, then `req_valid_o=0`. One `fifo_rd_i` pulse -> exactly one more request.
- **Redirect with in-flight requests:** redirect to 0x1003 with 2 outstanding -> both responses dropped; `fifo_flush_o` pulses once; next request is 0x1000.
- **Simultaneous events:** redirect in the same cycle as an accept and a response -> `discard` counts the accepted request only; no stale push appears.
- **Wrap-around:** `redirect_pc_i`=0xFFFF_FFFC -> next addresses are 0xFFFF_FFFC, 0x0000_0000.
- **Error build:** with `IF_PREFETCH_ERR_EN`, `rsp_err_i` on the 3rd response -> 2 pushes, `fetch_err_o=1`, no further requests until reset.

Source files
------------

// File: rtl/tiny_pkg.sv
// Shared front-end definitions: data widths, boot address, prefetch FSM
// state encoding and the {pc, instr} packet written into the instruction FIFO.
package tiny_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/prefetch_credit.sv
// Saturating count of instruction FIFO slots not yet reserved by a fetch.
// A reserve and a release in the same cycle cancel; reload wins over both.
module prefetch_credit #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_reserve,
  input  logic i_release,
  input  logic i_reload,
  output logic o_avail
);

  localparam int             CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  logic [CW-1:0] r_credits;

  // Credit counter: reload on flush, otherwise reserve/release with saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= FULL;
    end else if (i_reload) begin
      r_credits <= FULL;
    end else if (i_reserve && !i_release) begin
      if (r_credits != '0) r_credits <= r_credits - 1'b1;
    end else if (i_release && !i_reserve) begin
      if (r_credits != FULL) r_credits <= r_credits + 1'b1;
    end
  end

  assign o_avail = (r_credits != '0);

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch stage: sequential word fetches with up to MAX_OUT
// requests in flight, registered pushes of {pc, instr} into the instruction
// FIFO, credit-based overflow protection, redirect with stale-response drop.
// Optional feature macro: IF_PREFETCH_ERR_EN (bus errors halt fetching and
// raise a sticky fetch_err_o).
//
// state | meaning
// BOOT  | one cycle after reset, loads the boot PC
// FETCH | issuing requests and pushing responses
// FLUSH | waiting for stale responses to drain, no new requests
// HALT  | stopped on a bus error until reset (error build only)
module if_prefetch #(
  parameter int              XLEN       = tiny_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(tiny_pkg::RESET_PC),
  parameter int              MAX_OUT    = 2,
  parameter int              FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [XLEN-1:0]   req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [XLEN-1:0]   rsp_data_i,
  input  logic              rsp_err_i,
  output logic              fifo_wr_en_o,
  output logic [2*XLEN-1:0] fifo_data_o,
  input  logic              fifo_rd_i,
  output logic              fifo_flush_o
`ifdef IF_PREFETCH_ERR_EN
  ,
  output logic              fetch_err_o
`endif
);

  import tiny_pkg::*;

  localparam int            OW        = 3;
  localparam logic [OW-1:0] MAX_OUT_W = OW'(MAX_OUT);

  if_state_e r_state;
  if_state_e w_state_nxt;

  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_rsp_pc;
  logic [OW-1:0]     r_out;
  logic [OW-1:0]     r_discard;
  logic              r_fifo_wr;
  logic [2*XLEN-1:0] r_fifo_data;
  logic              r_flush;

  logic              w_req_valid;
  logic              w_accept;
  logic              w_redir;
  logic              w_live;
  logic              w_push;
  logic              w_credit_ok;
  logic [OW-1:0]     w_out_nxt;
  logic [OW-1:0]     w_pend_after;
  logic [OW-1:0]     w_discard_nxt;
  logic [XLEN-1:0]   w_redir_pc;
  logic              w_unused;

`ifdef IF_PREFETCH_ERR_EN
  logic r_err;
  logic w_err;
`endif

  assign w_redir_pc   = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_unused     = ^{rsp_err_i, redirect_pc_i[1:0]};
  assign w_accept     = w_req_valid && req_ready_i;
  assign w_pend_after = r_out - {{(OW-1){1'b0}}, rsp_valid_i};
  assign w_out_nxt    = r_out + {{(OW-1){1'b0}}, w_accept} - {{(OW-1){1'b0}}, rsp_valid_i};

  // Stale-response bookkeeping: a redirect counts everything still in flight,
  // every later response drains one until the count is back to zero.
  always_comb begin
    w_discard_nxt = r_discard;
    if (w_redir) begin
      w_discard_nxt = w_out_nxt;
    end else if (rsp_valid_i && (r_discard != '0)) begin
      w_discard_nxt = r_discard - 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:  w_state_nxt = FETCH;
      FETCH: begin
        if (w_redir && (w_pend_after != '0)) w_state_nxt = FLUSH;
`ifdef IF_PREFETCH_ERR_EN
        if (w_err) w_state_nxt = HALT;
`endif
      end
      FLUSH: begin
        if (!w_redir && (w_discard_nxt == '0)) w_state_nxt = FETCH;
      end
`ifdef IF_PREFETCH_ERR_EN
      HALT:    w_state_nxt = HALT;
`endif
      default: w_state_nxt = BOOT;
    endcase
  end

  // FSM outputs: request issue, redirect acceptance and response routing.
  // A response arriving together with a redirect is stale and never pushed.
  always_comb begin
    w_req_valid = (r_state == FETCH) && (r_out < MAX_OUT_W) && w_credit_ok;
    w_redir     = redirect_i && ((r_state == FETCH) || (r_state == FLUSH));
    w_live      = rsp_valid_i && (r_state == FETCH) && (r_discard == '0) && !w_redir;
`ifdef IF_PREFETCH_ERR_EN
    w_err       = w_live && rsp_err_i;
    w_push      = w_live && !rsp_err_i;
`else
    w_push      = w_live;
`endif
  end

  // PC, in-flight counters and registered FIFO-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_rsp_pc    <= RESET_PC;
      r_out       <= '0;
      r_discard   <= '0;
      r_fifo_wr   <= 1'b0;
      r_fifo_data <= '0;
      r_flush     <= 1'b0;
    end else begin
      r_out     <= w_out_nxt;
      r_discard <= w_discard_nxt;
      r_flush   <= w_redir;
      r_fifo_wr <= w_push;
      if (w_push) r_fifo_data <= {r_rsp_pc, rsp_data_i};
      if (r_state == BOOT) begin
        r_fetch_pc <= RESET_PC;
        r_rsp_pc   <= RESET_PC;
      end else if (w_redir) begin
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push)   r_rsp_pc   <= r_rsp_pc + XLEN'(4);
      end
    end
  end

`ifdef IF_PREFETCH_ERR_EN
  // Sticky bus-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_err <= 1'b0;
    else if (w_err) r_err <= 1'b1;
  end

  assign fetch_err_o = r_err;
`endif

  prefetch_credit #(
    .DEPTH (FIFO_DEPTH)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_reserve (w_accept),
    .i_release (fifo_rd_i),
    .i_reload  (w_redir),
    .o_avail   (w_credit_ok)
  );

  assign req_valid_o  = w_req_valid;
  assign req_addr_o   = r_fetch_pc;
  assign fifo_wr_en_o = r_fifo_wr;
  assign fifo_data_o  = r_fifo_data;
  assign fifo_flush_o = r_flush;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: a vector table for boot/stream/redirect,
// plus hand sequences for backpressure, held responses, wrap and bus errors.
// The memory model answers in order, one cycle after acceptance.
module tb_if_prefetch;
  import tiny_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        rsp_err_i;
  logic        fifo_wr_en_o;
  logic [63:0] fifo_data_o;
  logic        fifo_rd_i;
  logic        fifo_flush_o;
`ifdef IF_PREFETCH_ERR_EN
  logic        fetch_err_o;
`endif

  if_prefetch #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .MAX_OUT    (2),
    .FIFO_DEPTH (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_addr_o    (req_addr_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_data_i    (rsp_data_i),
    .rsp_err_i     (rsp_err_i),
    .fifo_wr_en_o  (fifo_wr_en_o),
    .fifo_data_o   (fifo_data_o),
    .fifo_rd_i     (fifo_rd_i),
    .fifo_flush_o  (fifo_flush_o)
`ifdef IF_PREFETCH_ERR_EN
    ,
    .fetch_err_o   (fetch_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] q_addr[$];
  int          q_t[$];
  logic [31:0] acc_log[$];
  logic [63:0] push_log[$];
  int          cyc;
  int          acc_cnt;
  int          flush_cnt;
  int          rsp_num;
  int          err_at;
  logic        mem_hold;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        rd;
    logic        e_valid;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [31:0] e_pc;
    logic        e_flush;
  } vec_t;

  vec_t vt[9];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [63:0] pkt(input logic [31:0] pc);
    fetch_pkt_t p;
    p.pc    = pc;
    p.instr = instr_of(pc);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, answer the memory side and
  // log what the DUT shows this cycle.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc, input logic rd);
    @(negedge clk);
    cyc++;
    req_ready_i   = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    fifo_rd_i     = rd;
    rsp_valid_i   = 1'b0;
    rsp_err_i     = 1'b0;
    rsp_data_i    = 32'h0;
    if (!mem_hold && (q_addr.size() > 0) && (q_t[0] < cyc)) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = instr_of(q_addr[0]);
      rsp_err_i   = (rsp_num == err_at);
      rsp_num++;
      void'(q_addr.pop_front());
      void'(q_t.pop_front());
    end
    if (req_valid_o && rdy) begin
      q_addr.push_back(req_addr_o);
      q_t.push_back(cyc);
      acc_log.push_back(req_addr_o);
      acc_cnt++;
    end
    if (fifo_wr_en_o) push_log.push_back(fifo_data_o);
    if (fifo_flush_o) flush_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    req_ready_i   = 1'b0;
    rsp_valid_i   = 1'b0;
    rsp_data_i    = 32'h0;
    rsp_err_i     = 1'b0;
    fifo_rd_i     = 1'b0;
    q_addr.delete();
    q_t.delete();
    mem_hold = 1'b0;
    err_at   = -1;
    rsp_num  = 0;
    #1;
    chk("rst_req_valid", req_valid_o, 0);
    chk("rst_req_addr", req_addr_o, 32'h0);
    chk("rst_wr_en", fifo_wr_en_o, 0);
    chk("rst_data", fifo_data_o, 64'h0);
    chk("rst_flush", fifo_flush_o, 0);
`ifdef IF_PREFETCH_ERR_EN
    chk("rst_fetch_err", fetch_err_o, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acc_log.delete();
    push_log.delete();
    cyc       = 0;
    acc_cnt   = 0;
    flush_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0;

    vt[0] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,      1'b0};
    vt[1] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0,      1'b0};
    vt[2] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0,      1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h4,      1'b0};
    vt[4] = '{1'b1, 1'b1, 32'h1003,   1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h8,      1'b0};
    vt[5] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0,      1'b1};
    vt[6] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_1004, 1'b0, 32'h0,      1'b0};
    vt[7] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_1008, 1'b1, 32'h1000,   1'b0};
    vt[8] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h0000_100C, 1'b1, 32'h1004,   1'b0};

    // Boot, streaming, then a redirect coinciding with an accept and a response.
    do_reset();
    chk("boot_no_req", req_valid_o, 0);
    for (int i = 0; i < 9; i++) begin
      tick(vt[i].rdy, vt[i].redir, vt[i].rpc, vt[i].rd);
      chk($sformatf("vec%0d_valid", i), req_valid_o, vt[i].e_valid);
      chk($sformatf("vec%0d_addr", i), req_addr_o, vt[i].e_addr);
      chk($sformatf("vec%0d_wr", i), fifo_wr_en_o, vt[i].e_wr);
      chk($sformatf("vec%0d_flush", i), fifo_flush_o, vt[i].e_flush);
      if (vt[i].e_wr) chk($sformatf("vec%0d_data", i), fifo_data_o, pkt(vt[i].e_pc));
    end

    // Backpressure: no pops, credits run out after 16 accepts.
    do_reset();
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("bp_accepts", acc_cnt, 16);
    chk("bp_valid_low", req_valid_o, 0);
    chk("bp_pushes", push_log.size(), 16);
    chk("bp_last_push", push_log[15], pkt(32'h3C));
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("bp_one_more", acc_cnt, 17);
    chk("bp_one_more_addr", acc_log[16], 32'h40);
    chk("bp_valid_low2", req_valid_o, 0);

    // Redirect with two requests held in flight.
    do_reset();
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("hold_valid_low", req_valid_o, 0);
    chk("hold_addr_stable", req_addr_o, 32'h8);
    tick(1'b1, 1'b1, 32'h1003, 1'b0);
    acc_log.delete();
    push_log.delete();
    mem_hold = 1'b0;
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("fl_flush_pulse", fifo_flush_o, 1);
    chk("fl_no_req", req_valid_o, 0);
    chk("fl_addr", req_addr_o, 32'h1000);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("fl_flush_once", flush_cnt, 1);
    chk("fl_acc_seen", acc_log.size() > 0, 1);
    chk("fl_first_acc", acc_log[0], 32'h1000);
    chk("fl_push_seen", push_log.size() > 0, 1);
    chk("fl_first_push", push_log[0], pkt(32'h1000));

    // Wrap-around of the fetch PC.
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    acc_log.delete();
    push_log.delete();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_acc_n", acc_log.size() >= 2, 1);
    chk("wrap_acc0", acc_log[0], 32'hFFFF_FFFC);
    chk("wrap_acc1", acc_log[1], 32'h0000_0000);
    chk("wrap_push_n", push_log.size() >= 2, 1);
    chk("wrap_push0", push_log[0], pkt(32'hFFFF_FFFC));
    chk("wrap_push1", push_log[1], pkt(32'h0000_0000));

    // Bus error on the third response.
    do_reset();
    err_at = 2;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
`ifdef IF_PREFETCH_ERR_EN
    chk("err_pushes", push_log.size(), 2);
    chk("err_flag", fetch_err_o, 1);
    chk("err_no_req", req_valid_o, 0);
    begin
      int acc_before;
      acc_before = acc_cnt;
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 32'h2000, 1'b1);
      chk("err_halted", acc_cnt, acc_before);
      chk("err_sticky", fetch_err_o, 1);
      chk("err_no_flush", flush_cnt, 0);
    end
`else
    chk("noerr_pushes", push_log.size() >= 3, 1);
    chk("noerr_push2", push_log[2], pkt(32'h8));
    chk("noerr_running", req_valid_o, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
